scan_shift_register: RTL
========================

// Module: scan_shift_register
// PURPOSE
//  Parametrised capture/shift/update scan register between SoC parallel buses and the JTAG serial path.
//  - Captures a LENGTH-bit SoC word, shifts it out serially, and shifts a new word in from jtagInput at the same time.
//  - After LENGTH shifts it transfers the shifted-in word to a shadow (update) register and pulses done.
//  - Adds shift-enable pause, selectable bit order, abort/restart and a completion handshake.
// PARAMETERS
//  LENGTH     32  scan chain length in bits; LENGTH >= 1
//  MSB_FIRST  0   0: shift out bit 0 first, in at bit LENGTH-1; 1: shift out bit LENGTH-1 first, in at bit 0
//  CNT_W      $clog2(LENGTH+1)  bit-counter width (derived; do not override)
// PORTS
//  clk         in   1       single clock, all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  load        in   1       capture socOutput and start a scan (IDLE/UPDATE); abort+restart in SHIFT
//  socOutput   in   LENGTH  parallel word from SoC to be scanned out
//  shiftEn     in   1       shift qualifier; low in SHIFT = hold (pause)
//  jtagInput   in   1       serial data shifted into the chain
//  jtagOutput  out  1       serial data out = current output-end bit of the shift register
//  shiftValid  out  1       high in cycles where a shift occurs (SHIFT && shiftEn && !load)
//  busy        out  1       high while state == SHIFT
//  done        out  1       one-cycle pulse in UPDATE state
//  socInput    out  LENGTH  update register: last complete shifted-in word
// BEHAVIOUR
//  Reset (rst=0, async):
//  - state=IDLE; shreg, cnt and socInput = 0.
//  - jtagOutput, shiftValid, busy and done = 0.
//  States: IDLE, SHIFT, UPDATE (2-bit encoded).
//  IDLE:
//  - load=1 -> shreg<=socOutput, cnt<=0, next SHIFT.
//  - Otherwise hold. shiftEn is ignored.
//  SHIFT:
//  - load=1 has priority: shreg<=socOutput, cnt<=0, stay in SHIFT. No done, socInput unchanged.
//  - Else shiftEn=1 -> shift 1 bit toward the output end, jtagInput enters the opposite end, cnt<=cnt+1.
//  - Shift with cnt==LENGTH-1 -> next UPDATE (LENGTH shifts total).
//  - Else shiftEn=0 -> hold all state.
//  UPDATE (exactly one cycle):
//  - socInput<=shreg and done=1.
//  - load=1 -> capture socOutput, cnt<=0, next SHIFT. Otherwise next IDLE.
//  Outputs:
//  - jtagOutput = shreg[0] (MSB_FIRST=0) or shreg[LENGTH-1] (MSB_FIRST=1). Register-driven, no comb path from inputs.
//  - First output bit is valid the cycle after load is accepted.
//  Latency: load accept -> done = LENGTH+1 cycles with shiftEn held high. Each low shiftEn cycle adds 1.
//  LENGTH=1: one shift then UPDATE; cnt compare must not underflow.
//  socInput changes only in UPDATE; it is stable during SHIFT and IDLE.
//  Reset mid-SHIFT: the scan is discarded and socInput returns to 0.
// TESTING (LENGTH=8 unless noted)
//  1 Reset: rst=0 mid-scan, no clock edge -> all outputs 0 immediately; state IDLE after release.
//  2 Basic scan, MSB_FIRST=0:
//    - Stimulus: load with socOutput=8'hA5, shiftEn=1, jtagInput sequence 1,0,1,1,0,0,1,0.
//    - jtagOutput bits 1,0,1,0,0,1,0,1.
//    - done pulses 9 cycles after load; socInput=8'h4D.
//  3 MSB_FIRST=1, socOutput=8'h84 -> jtagOutput bits 1,0,0,0,0,1,0,0; jtagInput all 1 -> socInput=8'hFF.
//  4 Pause: shiftEn low for 3 cycles mid-scan -> jtagOutput, cnt and busy held; done arrives 12 cycles after load.
//  5 Abort: load=1 with socOutput=8'h3C after 4 shifts ->
//    - Restart: no done pulse, socInput unchanged.
//    - Next 8 jtagOutput bits = 0,0,1,1,1,1,0,0.
//  6 Back-to-back: load=1 in UPDATE cycle -> done pulse, socInput updated, new scan starts with busy=1 next cycle; LENGTH=1 and LENGTH=32 variants pass.

Source files
------------

// File: rtl/scan_shift_register.sv
// Capture/shift/update scan register bridging a parallel SoC word and the JTAG serial path.
// Latency: load accept -> done is LENGTH+1 cycles with shiftEn high; each paused cycle adds one.
// Backpressure: shiftEn low in SHIFT freezes the chain; load in SHIFT aborts and restarts the scan.
module scan_shift_register #(
  parameter int LENGTH    = 32,
  parameter bit MSB_FIRST = 1'b0,
  parameter int CNT_W     = $clog2(LENGTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LENGTH-1:0] socOutput,
  input  logic              shiftEn,
  input  logic              jtagInput,
  output logic              jtagOutput,
  output logic              shiftValid,
  output logic              busy,
  output logic              done,
  output logic [LENGTH-1:0] socInput
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;

  logic [1:0]        state;
  logic [LENGTH-1:0] shreg;
  logic [LENGTH-1:0] shifted;
  logic [CNT_W-1:0]  cnt;
  logic              last_shift;

  // Compare against LENGTH-1 as a constant so LENGTH=1 never needs cnt-1.
  assign last_shift = (cnt == CNT_W'(LENGTH - 1));

  // Next chain contents for one shift: data moves toward the output end,
  // jtagInput enters at the far end.
  generate
    if (LENGTH == 1) begin : g_one
      assign shifted = jtagInput;
    end else if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg[LENGTH-2:0], jtagInput};
    end else begin : g_lsb
      assign shifted = {jtagInput, shreg[LENGTH-1:1]};
    end
  endgenerate

  // Serial output comes straight from the chain flop at the output end.
  assign jtagOutput = MSB_FIRST ? shreg[LENGTH-1] : shreg[0];
  assign busy       = (state == ST_SHIFT);
  assign done       = (state == ST_UPDATE);
  assign shiftValid = (state == ST_SHIFT) && shiftEn && !load;

  // Scan sequencing: capture, shift with pause/abort, one-cycle update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cnt      <= '0;
      socInput <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            shreg <= socOutput;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (load) begin
            // Abort: restart on the new word, nothing is committed.
            shreg <= socOutput;
            cnt   <= '0;
          end else if (shiftEn) begin
            shreg <= shifted;
            cnt   <= cnt + CNT_W'(1);
            if (last_shift) begin
              state <= ST_UPDATE;
            end
          end
        end
        ST_UPDATE: begin
          socInput <= shreg;
          if (load) begin
            shreg <= socOutput;
            cnt   <= '0;
            state <= ST_SHIFT;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
